// File: rtl/udp_rx_header_strip_32.sv
// UDP receive header stripper, 32-bit datapath.
// Parses a 7-word IPv4+UDP header (no IP options), checks version/IHL,
// protocol, destination port and UDP length, publishes the header fields
// and forwards the UDP payload with zero latency.
//
// Handshake: a word moves across a side on any rising edge where that
// side's valid and ready are both high; valid never waits for ready and
// data is only meaningful while valid is high.
module udp_rx_header_strip_32 #(
    parameter logic [15:0] LOCAL_PORT = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_sop,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_bytes,
    input  logic        out_ready,
    output logic        hdr_valid,
    output logic [31:0] hdr_src_ip,
    output logic [31:0] hdr_dst_ip,
    output logic [15:0] hdr_src_port,
    output logic [15:0] hdr_dst_port,
    output logic [15:0] hdr_payload_len,
    output logic        pkt_drop,
    output logic        pkt_abort,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_drop_cnt,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [14:0] r_rem;
    logic        r_first;
    logic [2:0]  r_last_bytes;
    logic [31:0] r_sh_src_ip;
    logic [31:0] r_sh_dst_ip;
    logic [31:0] r_sh_ports;
    logic        r_hdr_valid;
    logic        r_pkt_drop;
    logic        r_pkt_abort;
    logic [31:0] r_hdr_src_ip;
    logic [31:0] r_hdr_dst_ip;
    logic [15:0] r_hdr_src_port;
    logic [15:0] r_hdr_dst_port;
    logic [15:0] r_hdr_payload_len;
    logic [15:0] r_ok_cnt;
    logic [15:0] r_drop_cnt;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_drop;
    logic        w_abort;
    logic        w_hdr_ok;
    logic        w_ok;
    logic        w_ld_idx1;
    logic        w_idx_inc;
    logic        w_pay_xfer;
    logic        w_fail;

    // Per-word header checks, evaluated on the word currently presented.
    logic        w_w0_ok;
    logic        w_proto_ok;
    logic        w_port_ok;
    logic        w_len_ok;
    logic [15:0] w_plen;
    logic [14:0] w_rem_load;
    logic [2:0]  w_last_bytes;

    assign w_w0_ok      = (in_data[31:24] == 8'h45);
    assign w_proto_ok   = (in_data[23:16] == 8'd17);
    assign w_port_ok    = (LOCAL_PORT == 16'd0) || (in_data[15:0] == LOCAL_PORT);
    assign w_len_ok     = (in_data[31:16] >= 16'd8);
    assign w_plen       = in_data[31:16] - 16'd8;
    // ceil(payload_len / 4) and bytes in the last word (1..4).
    assign w_rem_load   = {1'b0, w_plen[15:2]} + {14'd0, (w_plen[1:0] != 2'b00)};
    assign w_last_bytes = (w_plen[1:0] == 2'b00) ? 3'd4 : {1'b0, w_plen[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and handshake/control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_drop      = 1'b0;
        w_abort     = 1'b0;
        w_hdr_ok    = 1'b0;
        w_ok        = 1'b0;
        w_ld_idx1   = 1'b0;
        w_idx_inc   = 1'b0;
        w_pay_xfer  = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && in_sop) begin
                    if (w_w0_ok) begin
                        w_ld_idx1   = 1'b1;
                        w_state_nxt = S_HDR;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (in_valid && in_sop) begin
                    // New packet starts before the header finished.
                    w_drop = 1'b1;
                    if (w_w0_ok) w_ld_idx1   = 1'b1;
                    else         w_state_nxt = S_IDLE;
                end else if (in_valid) begin
                    w_idx_inc = 1'b1;
                    case (r_idx)
                        3'd2:    w_fail = !w_proto_ok;
                        3'd5:    w_fail = !w_port_ok;
                        3'd6:    w_fail = !w_len_ok;
                        default: w_fail = 1'b0;
                    endcase
                    if (w_fail) begin
                        w_drop      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_idx == 3'd6) begin
                        w_hdr_ok = 1'b1;
                        if (w_plen == 16'd0) begin
                            w_ok        = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_valid && in_sop) begin
                    // Truncated payload: swallow the sop word as the next header.
                    w_abort = 1'b1;
                    if (w_w0_ok) begin
                        w_ld_idx1   = 1'b1;
                        w_state_nxt = S_HDR;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_in_ready  = out_ready;
                    w_out_valid = in_valid;
                    if (in_valid && out_ready) begin
                        w_pay_xfer = 1'b1;
                        if (r_rem == 15'd1) begin
                            w_ok        = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Header word index: 1 after a sop word, cleared whenever HDR is left.
    always_ff @(posedge clk) begin
        if (rst)                       r_idx <= 3'd0;
        else if (w_ld_idx1)            r_idx <= 3'd1;
        else if (w_state_nxt != S_HDR) r_idx <= 3'd0;
        else if (w_idx_inc)            r_idx <= r_idx + 3'd1;
    end

    // Shadow copies of header fields; published only once all checks pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_src_ip <= 32'd0;
            r_sh_dst_ip <= 32'd0;
            r_sh_ports  <= 32'd0;
        end else if (w_idx_inc) begin
            if (r_idx == 3'd3) r_sh_src_ip <= in_data;
            if (r_idx == 3'd4) r_sh_dst_ip <= in_data;
            if (r_idx == 3'd5) r_sh_ports  <= in_data;
        end
    end

    // Payload tracking: remaining words, first-word flag, last-word byte count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem        <= 15'd0;
            r_first      <= 1'b0;
            r_last_bytes <= 3'd4;
        end else if (w_hdr_ok) begin
            r_rem        <= w_rem_load;
            r_first      <= 1'b1;
            r_last_bytes <= w_last_bytes;
        end else if (w_pay_xfer) begin
            r_rem   <= r_rem - 15'd1;
            r_first <= 1'b0;
        end
    end

    // Published header fields and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_valid       <= 1'b0;
            r_pkt_drop        <= 1'b0;
            r_pkt_abort       <= 1'b0;
            r_hdr_src_ip      <= 32'd0;
            r_hdr_dst_ip      <= 32'd0;
            r_hdr_src_port    <= 16'd0;
            r_hdr_dst_port    <= 16'd0;
            r_hdr_payload_len <= 16'd0;
        end else begin
            r_hdr_valid <= w_hdr_ok;
            r_pkt_drop  <= w_drop;
            r_pkt_abort <= w_abort;
            if (w_hdr_ok) begin
                r_hdr_src_ip      <= r_sh_src_ip;
                r_hdr_dst_ip      <= r_sh_dst_ip;
                r_hdr_src_port    <= r_sh_ports[31:16];
                r_hdr_dst_port    <= r_sh_ports[15:0];
                r_hdr_payload_len <= w_plen;
            end
        end
    end

    // Wrapping packet counters; drop/abort and ok are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok_cnt   <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_ok)              r_ok_cnt   <= r_ok_cnt + 16'd1;
            if (w_drop || w_abort) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = w_out_valid;
    assign out_data        = in_data;
    assign out_sop         = w_out_valid && r_first;
    assign out_eop         = w_out_valid && (r_rem == 15'd1);
    assign out_bytes       = (r_rem == 15'd1) ? r_last_bytes : 3'd4;
    assign hdr_valid       = r_hdr_valid;
    assign hdr_src_ip      = r_hdr_src_ip;
    assign hdr_dst_ip      = r_hdr_dst_ip;
    assign hdr_src_port    = r_hdr_src_port;
    assign hdr_dst_port    = r_hdr_dst_port;
    assign hdr_payload_len = r_hdr_payload_len;
    assign pkt_drop        = r_pkt_drop;
    assign pkt_abort       = r_pkt_abort;
    assign pkt_ok_cnt      = r_ok_cnt;
    assign pkt_drop_cnt    = r_drop_cnt;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_udp_rx_header_strip_32.sv
// Bench for udp_rx_header_strip_32: a per-cycle vector table for whole
// packets, plus hand-written sequences for backpressure, mid-payload abort
// and reset in the middle of a header.
module tb_udp_rx_header_strip_32;

    localparam logic [15:0] LPORT = 16'd5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_sop;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_bytes;
    logic        out_ready;
    logic        hdr_valid;
    logic [31:0] hdr_src_ip;
    logic [31:0] hdr_dst_ip;
    logic [15:0] hdr_src_port;
    logic [15:0] hdr_dst_port;
    logic [15:0] hdr_payload_len;
    logic        pkt_drop;
    logic        pkt_abort;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_drop_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    udp_rx_header_strip_32 #(.LOCAL_PORT(LPORT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_bytes(out_bytes), .out_ready(out_ready),
        .hdr_valid(hdr_valid), .hdr_src_ip(hdr_src_ip), .hdr_dst_ip(hdr_dst_ip),
        .hdr_src_port(hdr_src_port), .hdr_dst_port(hdr_dst_port),
        .hdr_payload_len(hdr_payload_len),
        .pkt_drop(pkt_drop), .pkt_abort(pkt_abort),
        .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt),
        .o_dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sop;
        logic [31:0] data;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_osop;
        logic        e_oeop;
        logic [2:0]  e_ob;
        logic        e_hv;
        logic [15:0] e_plen;
        logic        e_drop;
        logic        e_abort;
        logic [15:0] e_ok;
        logic [15:0] e_dcnt;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] cur_ok   = 16'd0;
    logic [15:0] cur_drop = 16'd0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sop   = s;
        in_data  = d;
    endtask

    // Header word k of an IPv4 (IHL=5) + UDP header.
    function automatic logic [31:0] hw(input int k, input logic [7:0] proto, input logic [15:0] sp,
                                       input logic [15:0] dp, input logic [15:0] len,
                                       input logic [31:0] sip);
        case (k)
            0:       return 32'h4500_0030;
            1:       return 32'h1c46_4000;
            2:       return {8'h40, proto, 16'hb1e6};
            3:       return sip;
            4:       return 32'hc0a8_0064;
            5:       return {sp, dp};
            default: return {len, 16'h0000};
        endcase
    endfunction

    task automatic add_row(input logic v, input logic s, input logic [31:0] d,
                           input logic ir, input logic ov, input logic [31:0] od,
                           input logic osop, input logic oeop, input logic [2:0] ob,
                           input logic hv, input logic [15:0] plen,
                           input logic drop, input logic abort);
        vec_t r;
        r.v = v; r.sop = s; r.data = d; r.ordy = 1'b1;
        r.e_ir = ir; r.e_ov = ov; r.e_od = od; r.e_osop = osop; r.e_oeop = oeop; r.e_ob = ob;
        r.e_hv = hv; r.e_plen = plen; r.e_drop = drop; r.e_abort = abort;
        r.e_ok = cur_ok; r.e_dcnt = cur_drop;
        vecs.push_back(r);
    endtask

    // Seven header rows; drop_at is the failing word index (-1: none), whose
    // drop pulse shows up one row later.
    task automatic add_hdr(input logic [7:0] proto, input logic [15:0] sp, input logic [15:0] dp,
                           input logic [15:0] len, input logic [31:0] sip, input int drop_at);
        for (int k = 0; k < 7; k++) begin
            logic d;
            d = (drop_at >= 0) && (k == drop_at + 1);
            if (d) cur_drop++;
            add_row(1'b1, k == 0, hw(k, proto, sp, dp, len, sip), 1'b1, 1'b0, 32'h0,
                    1'b0, 1'b0, 3'd0, 1'b0, 16'h0, d, 1'b0);
        end
    endtask

    task automatic add_idle(input logic hv, input logic [15:0] plen, input logic drop);
        add_row(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, hv, plen, drop, 1'b0);
    endtask

    task automatic add_pay(input logic [31:0] d, input logic osop, input logic oeop,
                           input logic [2:0] ob, input logic hv, input logic [15:0] plen);
        add_row(1'b1, 1'b0, d, 1'b1, 1'b1, d, osop, oeop, ob, hv, plen, 1'b0, 1'b0);
    endtask

    task automatic hdr_words(input int k0, input int k1, input logic [7:0] proto,
                             input logic [15:0] sp, input logic [15:0] dp,
                             input logic [15:0] len, input logic [31:0] sip);
        for (int k = k0; k <= k1; k++) begin
            drive(1'b1, k == 0, hw(k, proto, sp, dp, len, sip));
            @(negedge clk);
            check("hdr_in_ready", in_ready, 1'b1);
            check("hdr_no_out", out_valid, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [95:0] act;
        logic [95:0] exp;
        logic [31:0] popped;
        int          pi;
        int          n_eop;

        // Reset.
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ok_cnt", pkt_ok_cnt, 16'd0);
        check("rst_drop_cnt", pkt_drop_cnt, 16'd0);
        check("rst_pulses", {hdr_valid, pkt_drop, pkt_abort}, 3'b000);
        check("rst_fields", {hdr_src_ip, hdr_dst_ip, hdr_src_port, hdr_dst_port, hdr_payload_len}, 96'h0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_io", {in_ready, out_valid}, 2'b10);
        tick();

        // A: UDP len 13 -> 5 payload bytes in 2 words, last word 1 byte.
        add_hdr(8'd17, 16'd1111, LPORT, 16'd13, 32'hc0a8_0001, -1);
        add_pay(32'ha1a2_a3a4, 1'b1, 1'b0, 3'd4, 1'b1, 16'd5);
        add_pay(32'hb100_0000, 1'b0, 1'b1, 3'd1, 1'b0, 16'd0);
        cur_ok++;
        add_idle(1'b0, 16'd0, 1'b0);
        // B: TCP -> dropped after word 2; its payload word is discarded.
        add_hdr(8'd6, 16'd1111, LPORT, 16'd13, 32'hc0a8_0001, 2);
        add_row(1'b1, 1'b0, 32'hdead_beef, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        add_idle(1'b0, 16'd0, 1'b0);
        // C: UDP len 8 -> header only, counted ok.
        add_hdr(8'd17, 16'd1111, LPORT, 16'd8, 32'hc0a8_0001, -1);
        cur_ok++;
        add_idle(1'b1, 16'd0, 1'b0);
        // D: UDP len 7 -> dropped on word 6.
        add_hdr(8'd17, 16'd1111, LPORT, 16'd7, 32'hc0a8_0001, -1);
        cur_drop++;
        add_idle(1'b0, 16'd0, 1'b1);
        // E: wrong destination port -> dropped on word 5.
        add_hdr(8'd17, 16'd1111, 16'd80, 16'd13, 32'hc0a8_0001, 5);
        add_row(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        add_idle(1'b0, 16'd0, 1'b0);
        // F: 4-byte payload, single word with sop and eop.
        add_hdr(8'd17, 16'd1234, LPORT, 16'd12, 32'h0a01_0203, -1);
        add_pay(32'hf0f1_f2f3, 1'b1, 1'b1, 3'd4, 1'b1, 16'd4);
        cur_ok++;
        add_idle(1'b0, 16'd0, 1'b0);
        // G: 8-byte payload, full last word.
        add_hdr(8'd17, 16'd4321, LPORT, 16'd16, 32'h0a09_0807, -1);
        add_pay(32'h1111_2222, 1'b1, 1'b0, 3'd4, 1'b1, 16'd8);
        add_pay(32'h3333_4444, 1'b0, 1'b1, 3'd4, 1'b0, 16'd0);
        cur_ok++;
        add_idle(1'b0, 16'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].sop, vecs[i].data);
            out_ready = vecs[i].ordy;
            @(negedge clk);
            act = {in_ready, out_valid,
                   vecs[i].e_ov ? out_data : 32'h0,
                   vecs[i].e_ov ? out_sop : 1'b0,
                   vecs[i].e_ov ? out_eop : 1'b0,
                   vecs[i].e_ov ? out_bytes : 3'd0,
                   hdr_valid,
                   vecs[i].e_hv ? hdr_payload_len : 16'h0,
                   pkt_drop, pkt_abort, pkt_ok_cnt, pkt_drop_cnt};
            exp = {vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_osop, vecs[i].e_oeop,
                   vecs[i].e_ob, vecs[i].e_hv, vecs[i].e_plen, vecs[i].e_drop, vecs[i].e_abort,
                   vecs[i].e_ok, vecs[i].e_dcnt};
            check($sformatf("vec%0d", i), act, exp);
            tick();
        end
        check("tbl_fields", {hdr_src_ip, hdr_dst_ip, hdr_src_port, hdr_dst_port},
              {32'h0a09_0807, 32'hc0a8_0064, 16'd4321, LPORT});
        check("tbl_plen", hdr_payload_len, 16'd8);

        // Backpressure: 18-byte payload (5 words, 2 bytes last) with out_ready toggling.
        hdr_words(0, 6, 8'd17, 16'd7, LPORT, 16'd26, 32'h0a00_0001);
        for (int j = 0; j < 5; j++) exp_q.push_back(32'h5000_0000 + j);
        pi = 0;
        n_eop = 0;
        for (int c = 0; c < 40 && pi < 5; c++) begin
            out_ready = c[0];
            drive(1'b1, 1'b0, 32'h5000_0000 + pi);
            @(negedge clk);
            check("bp_in_ready", in_ready, out_ready);
            check("bp_out_valid", out_valid, 1'b1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_word", 1'b1, 1'b0);
                end else begin
                    popped = exp_q.pop_front();
                    check("bp_data", out_data, popped);
                end
                check("bp_sop", out_sop, pi == 0);
                check("bp_eop", out_eop, pi == 4);
                if (out_eop) begin
                    n_eop++;
                    check("bp_bytes", out_bytes, 3'd2);
                end
            end
            if (out_ready) pi++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_done", pi, 5);
        check("bp_q_empty", exp_q.size(), 0);
        check("bp_one_eop", n_eop, 1);
        check("bp_ok_cnt", pkt_ok_cnt, 16'd5);
        tick();

        // Abort: sop on the third word of a 10-word payload.
        hdr_words(0, 6, 8'd17, 16'd9, LPORT, 16'd48, 32'h0a00_0001);
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 1'b0, 32'h6000_0000 + j);
            @(negedge clk);
            check("ab_pay", {out_valid, out_data, out_sop, out_eop},
                  {1'b1, 32'h6000_0000 + j, j == 0, 1'b0});
            tick();
        end
        drive(1'b1, 1'b1, hw(0, 8'd17, 16'd2, LPORT, 16'd13, 32'h0a00_0002));
        @(negedge clk);
        check("ab_sop_word", {in_ready, out_valid, out_eop}, 3'b100);
        tick();
        for (int k = 1; k < 7; k++) begin
            drive(1'b1, 1'b0, hw(k, 8'd17, 16'd2, LPORT, 16'd13, 32'h0a00_0002));
            @(negedge clk);
            check("ab_pulse", pkt_abort, k == 1);
            check("ab_hdr_no_out", out_valid, 1'b0);
            check("ab_no_drop_pulse", pkt_drop, 1'b0);
            tick();
        end
        check("ab_drop_cnt", pkt_drop_cnt, 16'd4);
        drive(1'b1, 1'b0, 32'h7071_7273);
        @(negedge clk);
        check("ab2_hdr", {hdr_valid, hdr_payload_len, hdr_src_ip}, {1'b1, 16'd5, 32'h0a00_0002});
        check("ab2_w0", {out_valid, out_data, out_sop, out_eop}, {1'b1, 32'h7071_7273, 1'b1, 1'b0});
        tick();
        drive(1'b1, 1'b0, 32'h8000_0000);
        @(negedge clk);
        check("ab2_w1", {out_valid, out_data, out_sop, out_eop, out_bytes},
              {1'b1, 32'h8000_0000, 1'b0, 1'b1, 3'd1});
        tick();
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("ab_counts", {pkt_ok_cnt, pkt_drop_cnt}, {16'd6, 16'd4});
        tick();

        // Reset while the header index sits at 4.
        hdr_words(0, 3, 8'd17, 16'd3, LPORT, 16'd13, 32'h0a00_0003);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_counts", {pkt_ok_cnt, pkt_drop_cnt}, 32'h0);
        check("mr_pulses", {hdr_valid, pkt_drop, pkt_abort}, 3'b000);
        check("mr_fields", {hdr_src_ip, hdr_payload_len}, 48'h0);
        check("mr_state", dbg_state, 2'd0);
        tick();
        for (int k = 4; k < 8; k++) begin
            drive(1'b1, 1'b0, hw(k, 8'd17, 16'd3, LPORT, 16'd13, 32'h0a00_0003));
            @(negedge clk);
            check("mr_discard", {in_ready, out_valid, pkt_drop}, 3'b100);
            tick();
        end
        hdr_words(0, 6, 8'd17, 16'd3, LPORT, 16'd13, 32'h0a00_0004);
        drive(1'b1, 1'b0, 32'h9091_9293);
        @(negedge clk);
        check("mr_w0", {hdr_valid, out_valid, out_data, out_sop}, {1'b1, 1'b1, 32'h9091_9293, 1'b1});
        tick();
        drive(1'b1, 1'b0, 32'h9400_0000);
        @(negedge clk);
        check("mr_w1", {out_valid, out_eop, out_bytes}, {1'b1, 1'b1, 3'd1});
        tick();
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("mr_final", {pkt_ok_cnt, pkt_drop_cnt}, {16'd1, 16'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
